// File: rtl/pipeexe_stage.sv
// Execute stage of a five-stage MIPS-style pipeline: ID/EX register plus ALU,
// jal link-address and destination-register selection.
module pipeexe_stage (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] dpc4,
    input  logic [31:0] da,
    input  logic [31:0] db,
    input  logic [31:0] dimm,
    input  logic [4:0]  drn,
    input  logic [3:0]  daluc,
    input  logic        dwreg,
    input  logic        dm2reg,
    input  logic        dwmem,
    input  logic        daluimm,
    input  logic        dshift,
    input  logic        djal,
    input  logic        wpcir,
    output logic [31:0] ealu,
    output logic [31:0] eb,
    output logic [4:0]  ern,
    output logic        ewreg,
    output logic        em2reg,
    output logic        ewmem
);

    logic [31:0] epc4_q, ea_q, eb_q, eimm_q;
    logic [31:0] epc4_d, ea_d, eb_d, eimm_d;
    logic [4:0]  ern0_q, ern0_d;
    logic [3:0]  ealuc_q, ealuc_d;
    logic        ewreg_q, em2reg_q, ewmem_q, ealuimm_q, eshift_q, ejal_q;
    logic        ewreg_d, em2reg_d, ewmem_d, ealuimm_d, eshift_d, ejal_d;

    // A stalled decode stage (wpcir=0) turns the next execute slot into a bubble.
    always_comb begin
        epc4_d    = 32'd0;
        ea_d      = 32'd0;
        eb_d      = 32'd0;
        eimm_d    = 32'd0;
        ern0_d    = 5'd0;
        ealuc_d   = 4'd0;
        ewreg_d   = 1'b0;
        em2reg_d  = 1'b0;
        ewmem_d   = 1'b0;
        ealuimm_d = 1'b0;
        eshift_d  = 1'b0;
        ejal_d    = 1'b0;
        if (wpcir) begin
            epc4_d    = dpc4;
            ea_d      = da;
            eb_d      = db;
            eimm_d    = dimm;
            ern0_d    = drn;
            ealuc_d   = daluc;
            ewreg_d   = dwreg;
            em2reg_d  = dm2reg;
            ewmem_d   = dwmem;
            ealuimm_d = daluimm;
            eshift_d  = dshift;
            ejal_d    = djal;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            epc4_q    <= 32'd0;
            ea_q      <= 32'd0;
            eb_q      <= 32'd0;
            eimm_q    <= 32'd0;
            ern0_q    <= 5'd0;
            ealuc_q   <= 4'd0;
            ewreg_q   <= 1'b0;
            em2reg_q  <= 1'b0;
            ewmem_q   <= 1'b0;
            ealuimm_q <= 1'b0;
            eshift_q  <= 1'b0;
            ejal_q    <= 1'b0;
        end else begin
            epc4_q    <= epc4_d;
            ea_q      <= ea_d;
            eb_q      <= eb_d;
            eimm_q    <= eimm_d;
            ern0_q    <= ern0_d;
            ealuc_q   <= ealuc_d;
            ewreg_q   <= ewreg_d;
            em2reg_q  <= em2reg_d;
            ewmem_q   <= ewmem_d;
            ealuimm_q <= ealuimm_d;
            eshift_q  <= eshift_d;
            ejal_q    <= ejal_d;
        end
    end

    logic [31:0] alu_a, alu_b, alu_r;

    // Shift amount comes from the shamt field, which sits in imm[10:6].
    assign alu_a = eshift_q  ? {27'd0, eimm_q[10:6]} : ea_q;
    assign alu_b = ealuimm_q ? eimm_q : eb_q;

    always_comb begin
        alu_r = 32'd0;
        casez (ealuc_q)
            4'b?000: alu_r = alu_a + alu_b;
            4'b?100: alu_r = alu_a - alu_b;
            4'b?001: alu_r = alu_a & alu_b;
            4'b?101: alu_r = alu_a | alu_b;
            4'b?010: alu_r = alu_a ^ alu_b;
            4'b?110: alu_r = {alu_b[15:0], 16'd0};
            4'b0011: alu_r = alu_b << alu_a[4:0];
            4'b0111: alu_r = alu_b >> alu_a[4:0];
            4'b1111: alu_r = $unsigned($signed(alu_b) >>> alu_a[4:0]);
            default: alu_r = 32'd0;
        endcase
    end

    assign ealu   = ejal_q ? (epc4_q + 32'd4) : alu_r;
    assign ern    = ejal_q ? 5'd31 : ern0_q;
    assign eb     = eb_q;
    assign ewreg  = ewreg_q;
    assign em2reg = em2reg_q;
    assign ewmem  = ewmem_q;

endmodule

// File: tb/tb_pipeexe_stage.sv
// Directed bench for pipeexe_stage: hand-computed vectors checked one cycle
// after each capture edge.
module tb_pipeexe_stage;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] dpc4, da, db, dimm;
    logic [4:0]  drn;
    logic [3:0]  daluc;
    logic        dwreg, dm2reg, dwmem, daluimm, dshift, djal, wpcir;
    logic [31:0] ealu, eb;
    logic [4:0]  ern;
    logic        ewreg, em2reg, ewmem;

    int total = 0;
    int bad   = 0;

    pipeexe_stage dut (
        .clock(clock), .resetn(resetn),
        .dpc4(dpc4), .da(da), .db(db), .dimm(dimm), .drn(drn), .daluc(daluc),
        .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluimm(daluimm),
        .dshift(dshift), .djal(djal), .wpcir(wpcir),
        .ealu(ealu), .eb(eb), .ern(ern),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        dpc4 = 32'd0; da = 32'd0; db = 32'd0; dimm = 32'd0;
        drn = 5'd0; daluc = 4'd0;
        dwreg = 1'b0; dm2reg = 1'b0; dwmem = 1'b0;
        daluimm = 1'b0; dshift = 1'b0; djal = 1'b0; wpcir = 1'b1;
    endtask

    // Advance one capture edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic w, input logic m, input logic s);
        check({tag, ".ewreg"},  {31'd0, ewreg},  {31'd0, w});
        check({tag, ".em2reg"}, {31'd0, em2reg}, {31'd0, m});
        check({tag, ".ewmem"},  {31'd0, ewmem},  {31'd0, s});
    endtask

    initial begin
        clear_inputs();
        resetn = 1'b0;
        dwreg = 1'b1; dwmem = 1'b1; da = 32'hDEAD_BEEF;
        step();
        check("rst.ealu", ealu, 32'd0);
        check("rst.eb", eb, 32'd0);
        check("rst.ern", {27'd0, ern}, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);

        // add
        resetn = 1'b1;
        clear_inputs();
        da = 32'd5; db = 32'd7; daluc = 4'b0000; dwreg = 1'b1; drn = 5'd8;
        step();
        check("add.ealu", ealu, 32'd12);
        check("add.ern", {27'd0, ern}, 32'd8);
        check("add.eb", eb, 32'd7);
        check_flags("add", 1'b1, 1'b0, 1'b0);

        // add with upper code bit set wraps modulo 2^32
        clear_inputs();
        da = 32'hFFFF_FFFF; db = 32'd2; daluc = 4'b1000;
        step();
        check("addwrap.ealu", ealu, 32'd1);

        // sub with immediate operand; eb still carries db
        clear_inputs();
        da = 32'd0; db = 32'h0000_0055; dimm = 32'hFFFF_FFFF; daluimm = 1'b1; daluc = 4'b0100;
        step();
        check("subimm.ealu", ealu, 32'd1);
        check("subimm.eb", eb, 32'h0000_0055);

        // sra by shamt=4 (imm[10:6])
        clear_inputs();
        db = 32'h8000_0000; dimm = 32'h0000_0100; dshift = 1'b1; daluc = 4'b1111;
        step();
        check("sra.ealu", ealu, 32'hF800_0000);

        // srl by same shamt
        daluc = 4'b0111;
        step();
        check("srl.ealu", ealu, 32'h0800_0000);

        // sll by shamt=3
        clear_inputs();
        db = 32'd1; dimm = 32'h0000_00C0; dshift = 1'b1; daluc = 4'b0011;
        step();
        check("sll.ealu", ealu, 32'd8);

        // logic ops
        clear_inputs();
        da = 32'hF0F0_1234; db = 32'h0FF0_FFFF; daluc = 4'b0001;
        step();
        check("and.ealu", ealu, 32'h00F0_1234);
        daluc = 4'b0101;
        step();
        check("or.ealu", ealu, 32'hFFF0_FFFF);
        daluc = 4'b0010;
        step();
        check("xor.ealu", ealu, 32'hFF00_EDCB);

        // unassigned code yields zero
        clear_inputs();
        da = 32'd5; db = 32'd7; daluc = 4'b1011;
        step();
        check("undef.ealu", ealu, 32'd0);

        // jal
        clear_inputs();
        djal = 1'b1; dpc4 = 32'h0040_0008; dwreg = 1'b1; drn = 5'd3; da = 32'd1; db = 32'd1;
        step();
        check("jal.ealu", ealu, 32'h0040_000C);
        check("jal.ern", {27'd0, ern}, 32'd31);
        check_flags("jal", 1'b1, 1'b0, 1'b0);

        // stalled load becomes two bubbles, then captured on release
        clear_inputs();
        dm2reg = 1'b1; dwreg = 1'b1; drn = 5'd9; da = 32'h100; dimm = 32'h4;
        daluimm = 1'b1; wpcir = 1'b0;
        step();
        check("stall1.ealu", ealu, 32'd0);
        check("stall1.ern", {27'd0, ern}, 32'd0);
        check_flags("stall1", 1'b0, 1'b0, 1'b0);
        step();
        check_flags("stall2", 1'b0, 1'b0, 1'b0);
        wpcir = 1'b1;
        step();
        check_flags("load", 1'b1, 1'b1, 1'b0);
        check("load.ealu", ealu, 32'h104);
        check("load.ern", {27'd0, ern}, 32'd9);

        // store in flight, then reset discards it
        clear_inputs();
        dwmem = 1'b1; db = 32'hCAFE_F00D; da = 32'h20;
        step();
        check_flags("store", 1'b0, 1'b0, 1'b1);
        check("store.eb", eb, 32'hCAFE_F00D);
        resetn = 1'b0;
        step();
        check_flags("midrst", 1'b0, 1'b0, 1'b0);
        check("midrst.eb", eb, 32'd0);
        check("midrst.ealu", ealu, 32'd0);

        // reset wins over stall too
        wpcir = 1'b0;
        step();
        check_flags("rststall", 1'b0, 1'b0, 1'b0);

        // first edge after release captures lui
        resetn = 1'b1;
        clear_inputs();
        dimm = 32'h0000_1234; daluimm = 1'b1; daluc = 4'b0110; dwreg = 1'b1; drn = 5'd4;
        step();
        check("lui.ealu", ealu, 32'h1234_0000);
        check("lui.ern", {27'd0, ern}, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
